cpu_register_file_mp: RTL and testbench

Parametrised integer register file for the Rv32H core, replacing the fixed 32x32 tag-handshaked file. It keeps the tag-change request protocol and adds several features:
- configurable width, depth (RV32I/RV32E) and tag width;
- explicit read/write acknowledge tags;
- optional same-edge write-to-read bypass;
- a per-register busy scoreboard, so decode can detect operands still owned by an in-flight producer.

---
 rtl/cpu_register_file_mp.sv | 138 +++++++++++++
 tb/tb_cpu_register_file_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_register_file_mp.sv
// Parametrised integer register file with tag-change read/write/claim requests and a busy scoreboard.
// Reads and writes complete on the edge after the tag changes; there is no backpressure.
module cpu_register_file_mp #(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = 32,
    parameter int              TAG_WIDTH = 8,
    parameter logic [XLEN-1:0] SP_INIT   = 32'h0001_0400,
    parameter bit              BYPASS    = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [TAG_WIDTH-1:0] i_read_tag,
    input  logic [4:0]           i_read_rs1_idx,
    input  logic [4:0]           i_read_rs2_idx,
    output logic [XLEN-1:0]      o_rs1,
    output logic [XLEN-1:0]      o_rs2,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic [TAG_WIDTH-1:0] o_read_tag,
    input  logic [TAG_WIDTH-1:0] i_write_tag,
    input  logic [4:0]           i_write_rd_idx,
    input  logic [XLEN-1:0]      i_rd,
    output logic [TAG_WIDTH-1:0] o_write_tag,
    input  logic [TAG_WIDTH-1:0] i_claim_tag,
    input  logic [4:0]           i_claim_rd_idx
);

    localparam int IDX_WIDTH = 5;

    logic [XLEN-1:0]      r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] r_busy;
    logic [TAG_WIDTH-1:0] r_read_tag;
    logic [TAG_WIDTH-1:0] r_write_tag;
    logic [TAG_WIDTH-1:0] r_claim_tag;
    logic [XLEN-1:0]      r_rs1;
    logic [XLEN-1:0]      r_rs2;
    logic                 r_rs1_busy;
    logic                 r_rs2_busy;

    logic                 w_read_req;
    logic                 w_write_req;
    logic                 w_claim_req;
    logic                 w_rs1_hit;
    logic                 w_rs2_hit;
    logic [XLEN-1:0]      w_rs1_dat;
    logic [XLEN-1:0]      w_rs2_dat;
    logic                 w_rs1_busy;
    logic                 w_rs2_busy;

    assign w_read_req  = (i_read_tag  != r_read_tag);
    assign w_write_req = (i_write_tag != r_write_tag);
    assign w_claim_req = (i_claim_tag != r_claim_tag);

    // x0 and out-of-range indices never match the loop, so they read as zero / not busy.
    always_comb begin
        w_rs1_hit  = 1'b0;
        w_rs2_hit  = 1'b0;
        w_rs1_dat  = '0;
        w_rs2_dat  = '0;
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        for (int k = 1; k < REG_COUNT; k++) begin
            if (i_read_rs1_idx == IDX_WIDTH'(k)) begin
                w_rs1_hit  = 1'b1;
                w_rs1_dat  = r_regs[k];
                w_rs1_busy = r_busy[k];
            end
            if (i_read_rs2_idx == IDX_WIDTH'(k)) begin
                w_rs2_hit  = 1'b1;
                w_rs2_dat  = r_regs[k];
                w_rs2_busy = r_busy[k];
            end
        end
        if (BYPASS && w_write_req && w_rs1_hit && (i_write_rd_idx == i_read_rs1_idx)) begin
            w_rs1_dat  = i_rd;
            w_rs1_busy = 1'b0;
        end
        if (BYPASS && w_write_req && w_rs2_hit && (i_write_rd_idx == i_read_rs2_idx)) begin
            w_rs2_dat  = i_rd;
            w_rs2_busy = 1'b0;
        end
    end

    // A claim on the same edge as a write wins the busy bit: it names a newer producer.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                r_regs[k] <= (k == 2) ? SP_INIT : '0;
            end
            r_busy <= '0;
        end else begin
            for (int k = 1; k < REG_COUNT; k++) begin
                if (w_write_req && (i_write_rd_idx == IDX_WIDTH'(k))) begin
                    r_regs[k] <= i_rd;
                end
                if (w_claim_req && (i_claim_rd_idx == IDX_WIDTH'(k))) begin
                    r_busy[k] <= 1'b1;
                end else if (w_write_req && (i_write_rd_idx == IDX_WIDTH'(k))) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_read_tag  <= '0;
            r_write_tag <= '0;
            r_claim_tag <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs1_busy  <= 1'b0;
            r_rs2_busy  <= 1'b0;
        end else begin
            if (w_read_req) begin
                r_read_tag <= i_read_tag;
                r_rs1      <= w_rs1_dat;
                r_rs2      <= w_rs2_dat;
                r_rs1_busy <= w_rs1_busy;
                r_rs2_busy <= w_rs2_busy;
            end
            if (w_write_req) begin
                r_write_tag <= i_write_tag;
            end
            if (w_claim_req) begin
                r_claim_tag <= i_claim_tag;
            end
        end
    end

    assign o_rs1       = r_rs1;
    assign o_rs2       = r_rs2;
    assign o_rs1_busy  = r_rs1_busy;
    assign o_rs2_busy  = r_rs2_busy;
    assign o_read_tag  = r_read_tag;
    assign o_write_tag = r_write_tag;

endmodule

// File: tb/tb_cpu_register_file_mp.sv
// Directed-vector bench: instance 0 is the default file, 1 has BYPASS=0, 2 is a 16-register (RV32E) file.
module tb_cpu_register_file_mp;

    localparam logic [31:0] SP = 32'h0001_0400;

    logic        i_clock;
    logic        i_reset;
    logic [7:0]  i_read_tag;
    logic [4:0]  i_read_rs1_idx;
    logic [4:0]  i_read_rs2_idx;
    logic [7:0]  i_write_tag;
    logic [4:0]  i_write_rd_idx;
    logic [31:0] i_rd;
    logic [7:0]  i_claim_tag;
    logic [4:0]  i_claim_rd_idx;

    logic [31:0] rs1   [3];
    logic [31:0] rs2   [3];
    logic        rs1_b [3];
    logic        rs2_b [3];
    logic [7:0]  rtag  [3];
    logic [7:0]  wtag  [3];

    int n_vec  = 0;
    int n_miss = 0;

    cpu_register_file_mp u_dut_a (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_read_tag(i_read_tag), .i_read_rs1_idx(i_read_rs1_idx), .i_read_rs2_idx(i_read_rs2_idx),
        .o_rs1(rs1[0]), .o_rs2(rs2[0]), .o_rs1_busy(rs1_b[0]), .o_rs2_busy(rs2_b[0]),
        .o_read_tag(rtag[0]),
        .i_write_tag(i_write_tag), .i_write_rd_idx(i_write_rd_idx), .i_rd(i_rd),
        .o_write_tag(wtag[0]),
        .i_claim_tag(i_claim_tag), .i_claim_rd_idx(i_claim_rd_idx)
    );

    cpu_register_file_mp #(.BYPASS(1'b0)) u_dut_nobyp (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_read_tag(i_read_tag), .i_read_rs1_idx(i_read_rs1_idx), .i_read_rs2_idx(i_read_rs2_idx),
        .o_rs1(rs1[1]), .o_rs2(rs2[1]), .o_rs1_busy(rs1_b[1]), .o_rs2_busy(rs2_b[1]),
        .o_read_tag(rtag[1]),
        .i_write_tag(i_write_tag), .i_write_rd_idx(i_write_rd_idx), .i_rd(i_rd),
        .o_write_tag(wtag[1]),
        .i_claim_tag(i_claim_tag), .i_claim_rd_idx(i_claim_rd_idx)
    );

    cpu_register_file_mp #(.REG_COUNT(16)) u_dut_e (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_read_tag(i_read_tag), .i_read_rs1_idx(i_read_rs1_idx), .i_read_rs2_idx(i_read_rs2_idx),
        .o_rs1(rs1[2]), .o_rs2(rs2[2]), .o_rs1_busy(rs1_b[2]), .o_rs2_busy(rs2_b[2]),
        .o_read_tag(rtag[2]),
        .i_write_tag(i_write_tag), .i_write_rd_idx(i_write_rd_idx), .i_rd(i_rd),
        .o_write_tag(wtag[2]),
        .i_claim_tag(i_claim_tag), .i_claim_rd_idx(i_claim_rd_idx)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("%s_rs1_%0d", tag, j), rs1[j], 32'h0);
            check($sformatf("%s_rs2_%0d", tag, j), rs2[j], 32'h0);
            check($sformatf("%s_b1_%0d", tag, j), 32'(rs1_b[j]), 32'h0);
            check($sformatf("%s_b2_%0d", tag, j), 32'(rs2_b[j]), 32'h0);
            check($sformatf("%s_rtag_%0d", tag, j), 32'(rtag[j]), 32'h0);
            check($sformatf("%s_wtag_%0d", tag, j), 32'(wtag[j]), 32'h0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_read_tag = 8'h0; i_read_rs1_idx = 5'd0; i_read_rs2_idx = 5'd0;
        i_write_tag = 8'h0; i_write_rd_idx = 5'd0; i_rd = 32'h0;
        i_claim_tag = 8'h0; i_claim_rd_idx = 5'd0;
        #2;
        check_all_zero("rst");
        #20 i_reset = 1'b0;

        // 1: sp reset value, x0, and hold with tag unchanged
        i_read_tag = 8'd1; i_read_rs1_idx = 5'd2; i_read_rs2_idx = 5'd0;
        step();
        for (int j = 0; j < 3; j++) begin
            check($sformatf("sp_rs1_%0d", j), rs1[j], SP);
            check($sformatf("sp_rs2_%0d", j), rs2[j], 32'h0);
            check($sformatf("sp_rtag_%0d", j), 32'(rtag[j]), 32'd1);
        end
        i_read_rs1_idx = 5'd0;
        for (int c = 0; c < 5; c++) step();
        check("hold_rs1", rs1[0], SP);
        check("hold_rtag", 32'(rtag[0]), 32'd1);

        // 2: write then read; write to x0 acknowledged but discarded
        i_write_tag = 8'd1; i_write_rd_idx = 5'd5; i_rd = 32'hDEAD_BEEF;
        step();
        check("w5_wtag", 32'(wtag[0]), 32'd1);
        i_read_tag = 8'd2; i_read_rs1_idx = 5'd5;
        step();
        for (int j = 0; j < 3; j++) check($sformatf("r5_%0d", j), rs1[j], 32'hDEAD_BEEF);
        i_write_tag = 8'd2; i_write_rd_idx = 5'd0; i_rd = 32'h0000_1234;
        step();
        check("w0_wtag", 32'(wtag[0]), 32'd2);
        i_read_tag = 8'd3; i_read_rs1_idx = 5'd0;
        step();
        check("r0", rs1[0], 32'h0);

        // 3: same-edge write and read of x7
        i_write_tag = 8'd3; i_write_rd_idx = 5'd7; i_rd = 32'hCAFE_F00D;
        i_read_tag = 8'd4; i_read_rs1_idx = 5'd7; i_read_rs2_idx = 5'd7;
        step();
        check("byp_rs1", rs1[0], 32'hCAFE_F00D);
        check("byp_rs2", rs2[0], 32'hCAFE_F00D);
        check("nobyp_rs1", rs1[1], 32'h0);
        check("byp_e_rs1", rs1[2], 32'hCAFE_F00D);
        i_read_tag = 8'd5;
        step();
        check("nobyp_next", rs1[1], 32'hCAFE_F00D);

        // 4: busy scoreboard
        i_claim_tag = 8'd1; i_claim_rd_idx = 5'd9;
        step();
        i_read_tag = 8'd6; i_read_rs1_idx = 5'd2; i_read_rs2_idx = 5'd9;
        step();
        check("clm_b2", 32'(rs2_b[0]), 32'd1);
        check("clm_b1", 32'(rs1_b[0]), 32'd0);
        i_write_tag = 8'd4; i_write_rd_idx = 5'd9; i_rd = 32'h0000_0099;
        step();
        i_read_tag = 8'd7;
        step();
        check("wr_clr_b2", 32'(rs2_b[0]), 32'd0);
        check("wr_clr_rs2", rs2[0], 32'h0000_0099);
        i_claim_tag = 8'd2; i_write_tag = 8'd5; i_rd = 32'h0000_1999;
        step();
        i_read_tag = 8'd8;
        step();
        check("cw_b2", 32'(rs2_b[0]), 32'd1);
        check("cw_rs2", rs2[0], 32'h0000_1999);
        i_claim_tag = 8'd3; i_claim_rd_idx = 5'd11;
        i_read_tag = 8'd9; i_read_rs1_idx = 5'd11;
        step();
        check("rc_same_b1", 32'(rs1_b[0]), 32'd0);
        i_read_tag = 8'd10;
        step();
        check("rc_after_b1", 32'(rs1_b[0]), 32'd1);
        i_write_tag = 8'd6; i_write_rd_idx = 5'd11; i_rd = 32'h0000_000B;
        i_read_tag = 8'd11;
        step();
        check("byp_busy_b1", 32'(rs1_b[0]), 32'd0);
        check("byp_busy_rs1", rs1[0], 32'h0000_000B);
        check("nobyp_busy_b1", 32'(rs1_b[1]), 32'd1);
        check("nobyp_busy_rs1", rs1[1], 32'h0);

        // 5: out-of-range index on the 16-register instance
        i_write_tag = 8'd7; i_write_rd_idx = 5'd20; i_rd = 32'hFFFF_FFFF;
        i_claim_tag = 8'd4; i_claim_rd_idx = 5'd20;
        step();
        check("oor_wtag", 32'(wtag[2]), 32'd7);
        i_read_tag = 8'd12; i_read_rs1_idx = 5'd20; i_read_rs2_idx = 5'd4;
        step();
        check("r20_a", rs1[0], 32'hFFFF_FFFF);
        check("r20_a_b", 32'(rs1_b[0]), 32'd1);
        check("r20_e", rs1[2], 32'h0);
        check("r20_e_b", 32'(rs1_b[2]), 32'd0);
        check("r4_e", rs2[2], 32'h0);
        check("r4_e_b", 32'(rs2_b[2]), 32'd0);
        i_read_tag = 8'd13; i_read_rs1_idx = 5'd5; i_read_rs2_idx = 5'd7;
        step();
        check("e_r5", rs1[2], 32'hDEAD_BEEF);
        check("e_r7", rs2[2], 32'hCAFE_F00D);
        i_read_tag = 8'd14; i_read_rs1_idx = 5'd9; i_read_rs2_idx = 5'd11;
        step();
        check("e_r9", rs1[2], 32'h0000_1999);
        check("e_r11", rs2[2], 32'h0000_000B);

        // 6: tag wrap, then asynchronous reset with a write pending
        i_read_tag = 8'hFF;
        step();
        check("wrap_ff", 32'(rtag[0]), 32'h0000_00FF);
        i_read_tag = 8'h00;
        step();
        check("wrap_00", 32'(rtag[0]), 32'h0);
        i_write_tag = 8'd8; i_write_rd_idx = 5'd3; i_rd = 32'h0000_3333;
        i_read_tag = 8'd3; i_read_rs1_idx = 5'd2; i_read_rs2_idx = 5'd9;
        #2 i_reset = 1'b1;
        #1;
        check_all_zero("arst");
        i_write_tag = 8'd0; i_claim_tag = 8'd0;
        #2 i_reset = 1'b0;
        step();
        check("post_rtag", 32'(rtag[0]), 32'd3);
        check("post_sp", rs1[0], SP);
        check("post_r9", rs2[0], 32'h0);
        check("post_b9", 32'(rs2_b[0]), 32'd0);
        check("post_wtag", 32'(wtag[0]), 32'd0);
        i_read_tag = 8'd4; i_read_rs1_idx = 5'd3; i_read_rs2_idx = 5'd5;
        step();
        check("post_r3", rs1[0], 32'h0);
        check("post_r5", rs2[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
